pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the 3-stage core (IF → IF_ID → ID_EX → EX). It takes the redirect and hold requests raised by the execute stage, plus the instruction-bus hold request, and produces the PC redirect, stage flushes and per-stage stalls. It tracks post-branch flush sequencing, hold duration with a watchdog, and a taken-jump counter for bring-up. It sits between `ex` and the `pc_reg` / `if_id` / `id_ex` registers.

---
 rtl/pipe_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: turns EX redirect/hold requests and the
// instruction-bus hold into PC redirect, stage flushes and per-stage stalls.
module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MAX_HOLD     = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_flag_i,
    input  logic        bus_hold_req_i,
    output logic        pc_jump_en_o,
    output logic [31:0] pc_jump_addr_o,
    output logic        flush_o,
    output logic        stall_pc_o,
    output logic        stall_if_id_o,
    output logic        stall_id_ex_o,
    output logic        hold_timeout_o,
    output logic [15:0] jump_cnt_o
);

    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {RUN, FLUSH, HOLD} state_t;

    state_t        state, state_next;
    logic [2:0]    flush_cnt, flush_cnt_next;
    logic [HW-1:0] hold_cnt;
    logic [31:0]   target;
    logic [15:0]   jump_cnt;
    logic          timeout;
    logic          any_hold;

    assign any_hold = hold_flag_i | bus_hold_req_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            flush_cnt <= '0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
        end
    end

    // Latched target, bring-up jump counter and the hold watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            target   <= '0;
            jump_cnt <= '0;
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else if (jump_en_i) begin
            target   <= jump_addr_i;
            jump_cnt <= jump_cnt + 16'd1;
            hold_cnt <= '0;
        end else if (any_hold) begin
            if (hold_cnt != HW'(MAX_HOLD))
                hold_cnt <= hold_cnt + HW'(1);
            if (hold_cnt == HW'(MAX_HOLD - 1))
                timeout <= 1'b1;
        end else begin
            hold_cnt <= '0;
        end
    end

    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        if (jump_en_i) begin
            state_next     = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
            flush_cnt_next = 3'(FLUSH_CYCLES - 1);
        end else begin
            case (state)
                FLUSH: begin
                    flush_cnt_next = flush_cnt - 3'd1;
                    if (flush_cnt == 3'd1)
                        state_next = RUN;
                end
                default: state_next = any_hold ? HOLD : RUN;
            endcase
        end
    end

    // Mealy outputs; reset forces every output low in the same cycle.
    always_comb begin
        pc_jump_en_o   = 1'b0;
        pc_jump_addr_o = '0;
        flush_o        = 1'b0;
        stall_pc_o     = 1'b0;
        stall_if_id_o  = 1'b0;
        stall_id_ex_o  = 1'b0;
        hold_timeout_o = 1'b0;
        jump_cnt_o     = '0;
        if (!rst) begin
            hold_timeout_o = timeout;
            jump_cnt_o     = jump_cnt;
            if (jump_en_i) begin
                pc_jump_en_o   = 1'b1;
                pc_jump_addr_o = jump_addr_i;
                flush_o        = 1'b1;
            end else if (state == FLUSH) begin
                pc_jump_addr_o = target;
                flush_o        = 1'b1;
                stall_pc_o     = bus_hold_req_i;
            end else if (hold_flag_i) begin
                stall_pc_o    = 1'b1;
                stall_if_id_o = 1'b1;
                stall_id_ex_o = 1'b1;
            end else if (bus_hold_req_i) begin
                stall_pc_o    = 1'b1;
                stall_if_id_o = 1'b1;
                flush_o       = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl with FLUSH_CYCLES=2, MAX_HOLD=15.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        jump_en_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic        hold_flag_i = 1'b0;
    logic        bus_hold_req_i = 1'b0;
    logic        pc_jump_en_o;
    logic [31:0] pc_jump_addr_o;
    logic        flush_o;
    logic        stall_pc_o;
    logic        stall_if_id_o;
    logic        stall_id_ex_o;
    logic        hold_timeout_o;
    logic [15:0] jump_cnt_o;

    int checks = 0;
    int fails  = 0;
    logic [53:0] exp_q[$];

    always #5 clk = ~clk;

    pipe_ctrl #(.FLUSH_CYCLES(2), .MAX_HOLD(15)) dut (
        .clk(clk), .rst(rst),
        .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
        .hold_flag_i(hold_flag_i), .bus_hold_req_i(bus_hold_req_i),
        .pc_jump_en_o(pc_jump_en_o), .pc_jump_addr_o(pc_jump_addr_o),
        .flush_o(flush_o), .stall_pc_o(stall_pc_o),
        .stall_if_id_o(stall_if_id_o), .stall_id_ex_o(stall_id_ex_o),
        .hold_timeout_o(hold_timeout_o), .jump_cnt_o(jump_cnt_o)
    );

    // Packs {pc_jump_en, addr, flush, stall_pc, stall_if_id, stall_id_ex, timeout, jump_cnt}.
    function automatic logic [53:0] outs(input logic pje, input logic [31:0] addr,
                                         input logic fl, input logic spc, input logic sif,
                                         input logic sie, input logic to, input logic [15:0] jc);
        return {pje, addr, fl, spc, sif, sie, to, jc};
    endfunction

    task automatic step(input string tag, input logic r, input logic j, input logic [31:0] a,
                        input logic h, input logic b, input logic [53:0] e);
        logic [53:0] obs, expv;
        @(posedge clk);
        #2;
        rst = r; jump_en_i = j; jump_addr_i = a; hold_flag_i = h; bus_hold_req_i = b;
        exp_q.push_back(e);
        #2;
        obs = {pc_jump_en_o, pc_jump_addr_o, flush_o, stall_pc_o, stall_if_id_o,
               stall_id_ex_o, hold_timeout_o, jump_cnt_o};
        expv = exp_q.pop_front();
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    localparam logic [53:0] ZERO = '0;

    initial begin
        logic [15:0] jc;
        jc = 16'd0;

        // Reset with every input high: outputs must all read zero.
        for (int i = 0; i < 3; i++)
            step("reset", 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, ZERO);
        step("post_reset", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, ZERO);

        // Single redirect: one-cycle pulse, two flush cycles.
        step("redirect", 1'b0, 1'b1, 32'h40, 1'b0, 1'b0,
             outs(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, jc));
        jc++;
        step("flush_tail", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0,
             outs(1'b0, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, jc));
        step("redirect_done", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0,
             outs(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, jc));

        // EX hold for four cycles, then release.
        for (int i = 0; i < 4; i++)
            step("ex_hold", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0,
                 outs(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, jc));
        step("ex_release", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0,
             outs(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, jc));

        // Bus hold alone inserts a bubble into EX.
        for (int i = 0; i < 3; i++)
            step("bus_hold", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1,
                 outs(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, jc));
        step("bus_release", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0,
             outs(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, jc));

        // Redirect during HOLD, then a second redirect in flush cycle 1.
        step("enter_hold", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0,
             outs(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, jc));
        step("jump_over_hold", 1'b0, 1'b1, 32'h80, 1'b1, 1'b0,
             outs(1'b1, 32'h80, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, jc));
        jc++;
        step("jump_in_flush", 1'b0, 1'b1, 32'h100, 1'b1, 1'b0,
             outs(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, jc));
        jc++;
        step("flush_ignores_hold", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0,
             outs(1'b0, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, jc));
        step("flush_ext_done", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0,
             outs(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, jc));

        // Bus hold during FLUSH only freezes the PC.
        step("redirect2", 1'b0, 1'b1, 32'h200, 1'b0, 1'b0,
             outs(1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, jc));
        jc++;
        step("flush_bus_hold", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1,
             outs(1'b0, 32'h200, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, jc));
        step("flush2_done", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0,
             outs(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, jc));

        // Watchdog: timeout visible from the 16th held cycle and sticky.
        for (int i = 1; i <= 20; i++)
            step("watchdog_hold", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0,
                 outs(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, (i >= 16), jc));
        for (int i = 0; i < 2; i++)
            step("watchdog_sticky", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0,
                 outs(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, jc));
        step("watchdog_reset", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, ZERO);
        step("after_reset", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, ZERO);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
